// File: rtl/id_inst_buffer_pkg.sv
// Shared types and branch-decode constants for the ID-stage instruction buffer.
package id_inst_buffer_pkg;

   typedef logic [31:0] uint32_t;
   typedef logic [31:0] virt_t;

   typedef struct packed {
      uint32_t inst;
      virt_t   vaddr;
      logic    delayslot;
      logic    is_branch;
   } inst_buf_entry_t;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   // BEQ/BNE/BLEZ/BGTZ share the upper opcode bits 0001xx
   localparam logic [3:0] OP_BCOND_HI = 4'b0001;
   // JR/JALR share funct 00100x
   localparam logic [4:0] FUNCT_JREG_HI = 5'b00100;

endpackage

// File: rtl/id_inst_buffer_branch_predecode.sv
// Combinational branch detector for one fetch lane (opcode/funct fields only).
module branch_predecode
   import id_inst_buffer_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       is_branch
);

   always_comb begin
      is_branch = (opcode == OP_REGIMM) || (opcode == OP_J) || (opcode == OP_JAL) ||
                  (opcode[5:2] == OP_BCOND_HI) ||
                  ((opcode == OP_SPECIAL) && (funct[5:1] == FUNCT_JREG_HI));
   end

endmodule

// File: rtl/id_inst_buffer.sv
// Circular instruction queue between IF and the ID decoders; tags delay slots on
// enqueue and never presents a branch without its delay slot on multi-issue.
module id_inst_buffer
   import id_inst_buffer_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int N_ISSUE     = 2,
   parameter int DEPTH       = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic                                 ibus_valid,
   input  logic [FETCH_WIDTH-1:0][31:0]         ibus_rddata,
   input  logic [31:0]                          ibus_vaddr,
   input  logic [$clog2(FETCH_WIDTH):0]         ibus_nvalid,
   output logic                                 ready_o,
   output logic [N_ISSUE-1:0]                   issue_valid,
   output logic [N_ISSUE-1:0][31:0]             issue_inst,
   output logic [N_ISSUE-1:0][31:0]             issue_vaddr,
   output logic [N_ISSUE-1:0]                   issue_delayslot,
   input  logic [$clog2(N_ISSUE):0]             issue_num_i
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NV_W  = $clog2(FETCH_WIDTH) + 1;
   localparam int NI_W  = $clog2(N_ISSUE) + 1;

   inst_buf_entry_t        entries_q [DEPTH];
   inst_buf_entry_t        entries_d [DEPTH];
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   last_enq_branch_q, last_enq_branch_d;

   logic [FETCH_WIDTH-1:0] lane_is_branch;
   logic                   do_enq;
   logic                   prev_branch;
   logic [CNT_W-1:0]       n_enq, n_deq;
   logic [NI_W-1:0]        n_avail, n_valid, num_clamped;
   logic                   hold;
   inst_buf_entry_t        win [N_ISSUE];

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_predecode
      branch_predecode u_predecode (
         .opcode    (ibus_rddata[g][31:26]),
         .funct     (ibus_rddata[g][5:0]),
         .is_branch (lane_is_branch[g])
      );
   end

   assign ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);

   // A branch that is itself in a delay slot is never held, otherwise a
   // (malformed) branch pair would block the queue forever.
   always_comb begin
      n_avail = (count_q >= CNT_W'(N_ISSUE)) ? NI_W'(N_ISSUE) : NI_W'(count_q);
      hold    = 1'b0;
      for (int i = 0; i < N_ISSUE; i++) begin
         win[i] = entries_q[head_q + PTR_W'(i)];
         if ((N_ISSUE > 1) && (NI_W'(i + 1) == n_avail) &&
             win[i].is_branch && !win[i].delayslot) begin
            hold = 1'b1;
         end
      end
      n_valid     = n_avail - NI_W'(hold);
      num_clamped = (issue_num_i > n_valid) ? n_valid : issue_num_i;
      for (int i = 0; i < N_ISSUE; i++) begin
         issue_valid[i]     = (NI_W'(i) < n_valid) && !flush;
         issue_inst[i]      = issue_valid[i] ? win[i].inst      : '0;
         issue_vaddr[i]     = issue_valid[i] ? win[i].vaddr     : '0;
         issue_delayslot[i] = issue_valid[i] ? win[i].delayslot : 1'b0;
      end
   end

   always_comb begin
      entries_d         = entries_q;
      head_d            = head_q;
      tail_d            = tail_q;
      count_d           = count_q;
      last_enq_branch_d = last_enq_branch_q;
      n_enq             = '0;
      n_deq             = '0;
      prev_branch       = last_enq_branch_q;
      do_enq            = ibus_valid && ready_o && !flush;
      if (flush) begin
         head_d            = '0;
         tail_d            = '0;
         count_d           = '0;
         last_enq_branch_d = 1'b0;
      end else begin
         n_deq  = CNT_W'(num_clamped);
         head_d = head_q + PTR_W'(num_clamped);
         if (do_enq) begin
            n_enq  = CNT_W'(ibus_nvalid);
            tail_d = tail_q + PTR_W'(ibus_nvalid);
            for (int i = 0; i < FETCH_WIDTH; i++) begin
               if (NV_W'(i) < ibus_nvalid) begin
                  entries_d[tail_q + PTR_W'(i)] = '{inst:      ibus_rddata[i],
                                                    vaddr:     ibus_vaddr + 32'(4 * i),
                                                    delayslot: prev_branch,
                                                    is_branch: lane_is_branch[i]};
                  prev_branch = lane_is_branch[i];
               end
            end
            last_enq_branch_d = prev_branch;
         end
         count_d = count_q + n_enq - n_deq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q            <= '0;
         tail_q            <= '0;
         count_q           <= '0;
         last_enq_branch_q <= 1'b0;
      end else begin
         head_q            <= head_d;
         tail_q            <= tail_d;
         count_q           <= count_d;
         last_enq_branch_q <= last_enq_branch_d;
      end
   end

   // Payload storage carries no reset; validity comes from count/head only.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

   issue_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
      !flush |-> (issue_num_i <= n_valid));

endmodule

// File: tb/tb_id_inst_buffer.sv
// Self-checking bench for id_inst_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_id_inst_buffer;

   localparam int FW    = 2;
   localparam int NI    = 2;
   localparam int DEPTH = 8;

   localparam logic [31:0] BEQ   = 32'h10000003;
   localparam logic [31:0] ADDIU = 32'h24010001;
   localparam logic [31:0] NOP   = 32'h00000000;
   localparam logic [31:0] JR    = 32'h03e00008;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 flush = 1'b0;
   logic                 ibus_valid = 1'b0;
   logic [FW-1:0][31:0]  ibus_rddata = '0;
   logic [31:0]          ibus_vaddr = '0;
   logic [1:0]           ibus_nvalid = 2'd1;
   logic                 ready_o;
   logic [NI-1:0]        issue_valid;
   logic [NI-1:0][31:0]  issue_inst;
   logic [NI-1:0][31:0]  issue_vaddr;
   logic [NI-1:0]        issue_delayslot;
   logic [1:0]           issue_num_i = 2'd0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] vaddr;
      bit          ds;
      bit          br;
   } ment_t;

   ment_t mq[$];
   bit    mlast = 1'b0;

   id_inst_buffer #(.FETCH_WIDTH(FW), .N_ISSUE(NI), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .ibus_valid      (ibus_valid),
      .ibus_rddata     (ibus_rddata),
      .ibus_vaddr      (ibus_vaddr),
      .ibus_nvalid     (ibus_nvalid),
      .ready_o         (ready_o),
      .issue_valid     (issue_valid),
      .issue_inst      (issue_inst),
      .issue_vaddr     (issue_vaddr),
      .issue_delayslot (issue_delayslot),
      .issue_num_i     (issue_num_i)
   );

   always #5 clk = ~clk;

   // MIPS control-transfer instructions: opcodes 1..7, or SPECIAL with funct 8/9.
   function automatic bit refIsBranch(input logic [31:0] w);
      int op;
      int fn;
      op = int'(w[31:26]);
      fn = int'(w[5:0]);
      return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
   endfunction

   // Number of instructions the decoders may see: first NI entries, minus a
   // trailing branch whose delay slot is not also visible.
   function automatic int expCount();
      int n;
      n = (mq.size() < NI) ? mq.size() : NI;
      if (NI > 1 && n > 0 && mq[n-1].br && !mq[n-1].ds) n--;
      return n;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic [NI-1:0]       ev, eds;
      logic [NI-1:0][31:0] ei, ea;
      int n;
      n = flush ? 0 : expCount();
      ev = '0; eds = '0; ei = '0; ea = '0;
      for (int i = 0; i < n; i++) begin
         ev[i]  = 1'b1;
         eds[i] = mq[i].ds;
         ei[i]  = mq[i].inst;
         ea[i]  = mq[i].vaddr;
      end
      checkVal("ready", 64'(ready_o), 64'((DEPTH - mq.size()) >= FW));
      checkVal("issue_valid", 64'(issue_valid), 64'(ev));
      checkVal("issue_inst", 64'(issue_inst), 64'(ei));
      checkVal("issue_vaddr", 64'(issue_vaddr), 64'(ea));
      checkVal("issue_delayslot", 64'(issue_delayslot), 64'(eds));
   endtask

   // One clock step, entered and left at a falling edge.
   task automatic applyStimulus(input bit fl, input bit v, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] va,
                                input int nv, input int want_num);
      int          n, num;
      bit          acc, b;
      logic [31:0] w;
      n   = fl ? 0 : expCount();
      num = (want_num > n) ? n : want_num;
      flush          = fl;
      ibus_valid     = v;
      ibus_rddata[0] = w0;
      ibus_rddata[1] = w1;
      ibus_vaddr     = va;
      ibus_nvalid    = 2'(nv);
      issue_num_i    = fl ? 2'(want_num) : 2'(num);
      #1;
      checkOutput();
      acc = v && ((DEPTH - mq.size()) >= FW) && !fl;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         mlast = 1'b0;
      end else begin
         for (int k = 0; k < num; k++) void'(mq.pop_front());
         if (acc) begin
            for (int k = 0; k < nv; k++) begin
               w = (k == 0) ? w0 : w1;
               b = refIsBranch(w);
               mq.push_back('{inst: w, vaddr: va + 32'(4 * k), ds: mlast, br: b});
               mlast = b;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      flush       = 1'b0;
      ibus_valid  = 1'b0;
      issue_num_i = 2'd0;
      #1;
   endtask

   task automatic doFlush();
      applyStimulus(1'b1, 1'b0, NOP, NOP, 32'h0, 2, 0);
   endtask

   logic [31:0] pool [8];
   logic [31:0] exp_va;
   logic [31:0] ra, rb;
   int          consumed;

   initial begin
      pool = '{ADDIU, BEQ, NOP, JR, 32'h08000000, 32'h0000f809, 32'h8c000000, 32'h04000002};

      $display("[TB] reset state");
      repeat (2) @(negedge clk);
      checkVal("rst_ready", 64'(ready_o), 64'd1);
      checkVal("rst_valid", 64'(issue_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] fill to full");
      for (int b = 0; b < 4; b++) begin
         idle();
         checkVal("fill_ready", 64'(ready_o), 64'd1);
         applyStimulus(1'b0, 1'b1, ADDIU, ADDIU, 32'h1000 + 32'(8 * b), 2, 0);
      end
      idle();
      checkVal("full_ready", 64'(ready_o), 64'd0);
      applyStimulus(1'b0, 1'b1, ADDIU, ADDIU, 32'h2000, 2, 0);
      idle();
      checkVal("full_ready_held", 64'(ready_o), 64'd0);

      $display("[TB] async reset mid-beat");
      doFlush();
      applyStimulus(1'b0, 1'b1, ADDIU, ADDIU, 32'h3000, 2, 0);
      applyStimulus(1'b0, 1'b1, ADDIU, ADDIU, 32'h3008, 2, 0);
      applyStimulus(1'b0, 1'b1, BEQ, NOP, 32'h3010, 1, 0);
      ibus_valid  = 1'b1;
      ibus_nvalid = 2'd2;
      #2 rst_n = 1'b0;
      #1;
      checkVal("midrst_ready", 64'(ready_o), 64'd1);
      checkVal("midrst_valid", 64'(issue_valid), 64'd0);
      mq.delete();
      mlast = 1'b0;
      @(negedge clk);
      ibus_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, ADDIU, ADDIU, 32'h4000, 2, 0);
      idle();
      checkVal("postrst_valid", 64'(issue_valid), 64'b11);
      checkVal("postrst_ds", 64'(issue_delayslot), 64'b00);

      $display("[TB] same-beat branch pair");
      doFlush();
      applyStimulus(1'b0, 1'b1, BEQ, ADDIU, 32'hbfc00000, 2, 0);
      idle();
      checkVal("pair_valid", 64'(issue_valid), 64'b11);
      checkVal("pair_ds", 64'(issue_delayslot), 64'b10);
      checkVal("pair_vaddr0", 64'(issue_vaddr[0]), 64'hbfc00000);

      $display("[TB] branch held in last lane");
      doFlush();
      applyStimulus(1'b0, 1'b1, ADDIU, BEQ, 32'hbfc00100, 2, 0);
      idle();
      checkVal("held_valid", 64'(issue_valid), 64'b01);
      applyStimulus(1'b0, 1'b0, NOP, NOP, 32'h0, 2, 1);
      idle();
      checkVal("held_alone", 64'(issue_valid), 64'b00);
      applyStimulus(1'b0, 1'b1, NOP, ADDIU, 32'hbfc00108, 2, 0);
      idle();
      checkVal("held_pair_valid", 64'(issue_valid), 64'b11);
      checkVal("held_pair_ds", 64'(issue_delayslot), 64'b10);
      checkVal("held_pair_inst1", 64'(issue_inst[1]), 64'(NOP));

      $display("[TB] flush collision");
      doFlush();
      applyStimulus(1'b0, 1'b1, ADDIU, JR, 32'h5000, 2, 0);
      applyStimulus(1'b1, 1'b1, ADDIU, ADDIU, 32'h5008, 2, 2);
      idle();
      checkVal("flush_ready", 64'(ready_o), 64'd1);
      checkVal("flush_empty", 64'(issue_valid), 64'b00);
      applyStimulus(1'b0, 1'b1, ADDIU, ADDIU, 32'h6000, 1, 0);
      idle();
      checkVal("postflush_valid", 64'(issue_valid), 64'b01);
      checkVal("postflush_ds", 64'(issue_delayslot), 64'b00);

      $display("[TB] wrap-around");
      doFlush();
      exp_va   = 32'h7000;
      consumed = 0;
      for (int b = 0; b < 24; b++) begin
         applyStimulus(1'b0, b < 20, ADDIU, ADDIU, 32'h7000 + 32'(8 * b), 2, 2);
         idle();
         for (int i = 0; i < NI; i++) begin
            if (issue_valid[i]) begin
               checkVal("wrap_vaddr", 64'(issue_vaddr[i]), 64'(exp_va));
               exp_va = exp_va + 32'd4;
               consumed++;
            end
         end
      end
      checkVal("wrap_total", 64'(consumed), 64'd40);

      $display("[TB] randomized traffic");
      doFlush();
      for (int s = 0; s < 400; s++) begin
         ra = pool[$urandom_range(0, 7)] ^ ($urandom & 32'h03ffffc0);
         rb = pool[$urandom_range(0, 7)] ^ ($urandom & 32'h03ffffc0);
         applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, ra, rb,
                       $urandom & 32'hfffffffc, $urandom_range(1, 2), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_inst_buffer.md
# id_inst_buffer

Parametrised instruction buffer between the IF stage and the decoders in the ID stage. Each fetch beat it accepts up to FETCH_WIDTH instructions and holds them in a DEPTH-entry circular queue. Each cycle it presents up to N_ISSUE in-order instructions to the decoders. It tags delay-slot instructions at enqueue time and never issues a branch without its delay slot when N_ISSUE > 1. It replaces the single-entry inst save register and per-cycle delay-slot resolution of the single-issue ID stage.

## Interface
Parameters:
- FETCH_WIDTH, 2: instructions per fetch beat.
- N_ISSUE, 2: issue lanes.
- DEPTH, 8: queue entries. Must be a power of 2 and ≥ FETCH_WIDTH + N_ISSUE.

Ports:
- clk, in, 1: clock. Single clock domain.
- rst_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous flush, driven from except_req.valid.
- ibus_valid, in, 1: fetch beat present.
- ibus_rddata, in, FETCH_WIDTH×uint32_t: instruction words; lane i is at address ibus_vaddr + 4·i.
- ibus_vaddr, in, virt_t: address of lane 0.
- ibus_nvalid, in, $clog2(FETCH_WIDTH)+1: number of valid lanes (1..FETCH_WIDTH); lanes 0..ibus_nvalid-1 are valid.
- ready_o, out, 1: buffer can accept a full beat.
- issue_valid, out, N_ISSUE: per-lane valid. Contiguous from lane 0.
- issue_inst, out, N_ISSUE×uint32_t: instruction word per lane.
- issue_vaddr, out, N_ISSUE×virt_t: address per lane.
- issue_delayslot, out, N_ISSUE: lane holds a delay-slot instruction.
- issue_num_i, in, $clog2(N_ISSUE)+1: number of lanes consumed this cycle, counted from lane 0. Driven by the decode/ready logic.

## Operation
- State:
  - Entry array of inst_buf_entry_t.
  - head and tail pointers, $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
  - last_enq_branch flag.
- Enqueue when ibus_valid && ready_o && ~flush:
  - Write ibus_nvalid entries at tail, tail+1, …, modulo DEPTH.
  - Entry delayslot bit = 1 if the preceding enqueued instruction is a branch. Lane 0 uses last_enq_branch; lane i uses is_branch of lane i-1.
  - last_enq_branch takes is_branch of the last valid lane.
- Branch set (opcode = inst[31:26]): REGIMM 000001, J 000010, JAL 000011, 0001xx, and opcode 000000 with funct 00100x (JR/JALR).
- ready_o = (DEPTH − count) ≥ FETCH_WIDTH, computed from registered count only. No dependence on same-cycle dequeue.
- Issue window: entries head … head+N_ISSUE−1. Lane i is valid if i < count and no earlier lane is held.
- Branch hold: if N_ISSUE > 1 and the last valid lane holds a branch whose delay slot is not in a valid lane, that lane is invalid. The branch is re-presented with its slot once the slot is available.
- Dequeue: head += issue_num_i. issue_num_i above the valid-lane count is a protocol error; clamp it to the valid-lane count and flag it with an assertion.
- count_next = count + n_enq − n_deq. Simultaneous enqueue and dequeue are legal, including when count is at DEPTH − FETCH_WIDTH.
- Flush has priority over enqueue and dequeue:
  - head, tail, count and last_enq_branch go to 0.
  - issue_valid is forced to 0 combinationally in the flush cycle.
- Reset (rst_n low, asynchronous, any state, mid-beat included):
  - head, tail, count and last_enq_branch are 0.
  - ready_o = 1, all issue outputs 0.
  - Entry payload need not be reset.

## Timing
- Enqueue-to-issue latency is 1 cycle: a beat accepted at edge k is visible on the issue lanes after edge k. There is no combinational ibus→issue bypass.
- All issue outputs are combinational from registered state (plus flush). issue_num_i affects only next state.
- Full: count = DEPTH forces ready_o = 0. Empty: count = 0 forces issue_valid = 0.
- A beat is accepted only while ready_o is high. IF holds the beat otherwise.
- Pointer wrap is seamless across the DEPTH−1 → 0 boundary for both write and read windows.

## Structure
- Shared package (inst_decode.svh):
  - inst_buf_entry_t {uint32_t inst; virt_t vaddr; logic delayslot; logic is_branch}.
  - Branch opcode/funct constants.
- Sub-module: branch_predecode. Combinational; one instance per fetch lane; inst → is_branch.
- Queue storage, pointer/count logic and issue selection live in id_inst_buffer.

## Test plan
- **Async reset:** rst_n low mid-beat with count=5 → same cycle: count=0, ready_o=1, issue_valid=0. After release, first beat is issued with delayslot=0.
- **Fill to full** (DEPTH=8, FETCH_WIDTH=2, issue_num_i=0): ready_o stays 1 through 3 accepted beats (count 6). It drops to 0 after the 4th beat (count 8).
- **Same-beat pair:** beat {BEQ 0x10000003 @0xbfc00000, ADDIU @0xbfc00004} → next cycle issue_valid=2'b11, issue_delayslot=2'b10.
- **Branch held in last lane:** beat {ADDIU, BEQ}, then no fetch → issue_valid=2'b01 only. Next beat {NOP, …} arrives → BEQ+NOP issue together, NOP delayslot=1.
- **Flush collision:** flush, ibus_valid=1 and issue_num_i=2 in the same cycle → issue_valid=0 that cycle, count=0 next cycle, beat dropped. Last pre-flush instruction is a JR → first post-flush instruction has delayslot=0.
- **Wrap-around:** 20 beats of sequential addresses with issue_num_i=2 each cycle → issue_vaddr strictly increments by 4 across ≥2 pointer wraps, no loss or duplication.
